// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - stage payload types and pipeline constants
package cpu_types_pkg;

   localparam int PIPE_DEPTH_DEFAULT = 2;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1Val;
      logic [31:0] rs2Val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  aluOp;
      logic        memRead;
      logic        memWrite;
      logic        regWrite;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] aluResult;
      logic [31:0] storeData;
      logic [4:0]  rd;
      logic        memRead;
      logic        memWrite;
      logic        regWrite;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] wbData;
      logic [4:0]  rd;
      logic        regWrite;
   } mem_wb_t;

endpackage

// File: rtl/pipe_stage_if.sv
// rtl/pipe_stage_if.sv - valid/ready handshake bundle between two pipeline stages
interface pipe_stage_if #(
   parameter int PAYLOAD_W = 64
);
   logic                 in_valid;
   logic                 in_ready;
   logic [PAYLOAD_W-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [PAYLOAD_W-1:0] out_data;

   modport up (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport down (
      input  out_valid,
      input  out_data,
      output out_ready
   );
endinterface

// File: rtl/pipe_stage_fifo.sv
// rtl/pipe_stage_fifo.sv - elastic pipeline stage register with flush, bubble output and stall counter
module pipe_stage_fifo
   import cpu_types_pkg::*;
#(
   parameter int                   PAYLOAD_W = 64,
   parameter int                   DEPTH     = PIPE_DEPTH_DEFAULT,
   parameter logic [PAYLOAD_W-1:0] BUBBLE    = '0,
   parameter int                   CNT_W     = 16
) (
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [PAYLOAD_W-1:0]         in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PAYLOAD_W-1:0]         out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [CNT_W-1:0]             stall_cycles
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PAYLOAD_W-1:0] mem [DEPTH];
   logic [PW-1:0]        wrPtr;
   logic [PW-1:0]        rdPtr;
   logic                 push;
   logic                 pop;

   // Explicit wrap so non-power-of-two depths stay in range.
   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   assign out_data  = out_valid ? mem[rdPtr] : BUBBLE;

   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wrPtr] <= in_data;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= nextPtr(wrPtr);
         end
         if (pop) begin
            rdPtr <= nextPtr(rdPtr);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Survives flush so squashes do not hide back-pressure history.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cycles <= '0;
      end else if (out_valid && !out_ready && !flush && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb/tb_pipe_stage_fifo.sv - directed self-checking bench for pipe_stage_fifo
module tb_pipe_stage_fifo;

   logic CLK;
   logic nRST;

   logic        aFlush, aInValid, aInReady, aOutValid, aOutReady;
   logic [31:0] aInData, aOutData;
   logic [1:0]  aCount;
   logic [15:0] aStall;

   logic        bFlush, bInValid, bInReady, bOutValid, bOutReady;
   logic [31:0] bInData, bOutData;
   logic [1:0]  bCount;
   logic [15:0] bStall;

   logic        cFlush, cInValid, cInReady, cOutValid, cOutReady;
   logic [31:0] cInData, cOutData;
   logic [1:0]  cCount;
   logic [3:0]  cStall;

   int nChecks;
   int nFails;

   pipe_stage_fifo #(.PAYLOAD_W(32), .DEPTH(2), .BUBBLE(32'h0), .CNT_W(16)) dutA (
      .CLK(CLK), .nRST(nRST), .flush(aFlush),
      .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
      .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
      .count(aCount), .stall_cycles(aStall)
   );

   pipe_stage_fifo #(.PAYLOAD_W(32), .DEPTH(3), .BUBBLE(32'h0), .CNT_W(16)) dutB (
      .CLK(CLK), .nRST(nRST), .flush(bFlush),
      .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
      .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
      .count(bCount), .stall_cycles(bStall)
   );

   pipe_stage_fifo #(.PAYLOAD_W(32), .DEPTH(2), .BUBBLE(32'h0), .CNT_W(4)) dutC (
      .CLK(CLK), .nRST(nRST), .flush(cFlush),
      .in_valid(cInValid), .in_ready(cInReady), .in_data(cInData),
      .out_valid(cOutValid), .out_ready(cOutReady), .out_data(cOutData),
      .count(cCount), .stall_cycles(cStall)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      nChecks = 0;
      nFails  = 0;
      nRST = 1'b0;
      aFlush = 0; aInValid = 0; aInData = 0; aOutReady = 0;
      bFlush = 0; bInValid = 0; bInData = 0; bOutReady = 0;
      cFlush = 0; cInValid = 0; cInData = 0; cOutReady = 0;
      #12 nRST = 1'b1;
      step();

      chk("rst_count",     32'(aCount),    32'd0);
      chk("rst_out_valid", 32'(aOutValid), 32'd0);
      chk("rst_out_data",  aOutData,       32'h0);
      chk("rst_in_ready",  32'(aInReady),  32'd1);
      chk("rst_stall",     32'(aStall),    32'd0);

      // fill / drain
      aInValid = 1; aInData = 32'hA; step();
      chk("fill_count1",    32'(aCount), 32'd1);
      chk("fill_latency",   aOutData,    32'hA);
      aInData = 32'hB; step();
      chk("fill_count2",    32'(aCount),   32'd2);
      chk("fill_in_ready",  32'(aInReady), 32'd0);
      chk("fill_head",      aOutData,      32'hA);
      aInValid = 0; aOutReady = 1;
      chk("drain_first",    aOutData,      32'hA);
      step();
      chk("drain_second",   aOutData,      32'hB);
      chk("drain_count1",   32'(aCount),   32'd1);
      step();
      chk("drain_empty",    32'(aOutValid), 32'd0);
      chk("drain_bubble",   aOutData,       32'h0);
      chk("stall_after_fill", 32'(aStall),  32'd1);

      // full with simultaneous pop
      aOutReady = 0; aInValid = 1; aInData = 32'hA; step();
      aInData = 32'hB; step();
      chk("full_count", 32'(aCount), 32'd2);
      aInData = 32'hC; aOutReady = 1; step();
      chk("full_reject_count", 32'(aCount),   32'd1);
      chk("full_head_b",       aOutData,      32'hB);
      chk("full_in_ready",     32'(aInReady), 32'd1);
      step();
      chk("full_accept_count", 32'(aCount), 32'd1);
      chk("full_head_c",       aOutData,    32'hC);
      aInValid = 0; step();
      chk("full_drained", 32'(aCount), 32'd0);

      // flush with a push presented
      aOutReady = 0; aInValid = 1; aInData = 32'hA; step();
      aInData = 32'hB; step();
      chk("flush_pre_count", 32'(aCount), 32'd2);
      aInData = 32'hD; aFlush = 1; step();
      chk("flush_count",     32'(aCount),    32'd0);
      chk("flush_out_valid", 32'(aOutValid), 32'd0);
      chk("flush_bubble",    aOutData,       32'h0);
      aFlush = 0; aInValid = 0; step();
      chk("flush_no_d",      32'(aOutValid), 32'd0);
      chk("flush_keep_stall", 32'(aStall),   32'd3);

      // wrap-around streaming on DEPTH=3
      bInValid = 1; bOutReady = 1; bInData = 32'd1; step();
      chk("wrap_out_1",   bOutData,    32'd1);
      chk("wrap_count_1", 32'(bCount), 32'd1);
      for (int k = 2; k <= 7; k++) begin
         bInData = 32'(k);
         step();
         chk($sformatf("wrap_out_%0d", k),   bOutData,    32'(k));
         chk($sformatf("wrap_count_%0d", k), 32'(bCount), 32'd1);
      end
      bInValid = 0; step();
      chk("wrap_drained", 32'(bCount), 32'd0);

      // saturating stall counter, CNT_W=4
      cInValid = 1; cInData = 32'h5; step();
      cInValid = 0;
      repeat (20) step();
      chk("stall_sat",       32'(cStall),   32'd15);
      chk("stall_sat_head",  cOutData,      32'h5);
      cFlush = 1; step();
      cFlush = 0;
      chk("stall_flush_cnt", 32'(cCount),   32'd0);
      chk("stall_kept",      32'(cStall),   32'd15);

      // asynchronous reset mid-cycle with count=2
      aOutReady = 0; aInValid = 1; aInData = 32'hA; step();
      aInData = 32'hB; step();
      aInValid = 0;
      chk("areset_pre_count", 32'(aCount), 32'd2);
      #2 nRST = 1'b0;
      #1;
      chk("areset_count",     32'(aCount),    32'd0);
      chk("areset_out_valid", 32'(aOutValid), 32'd0);
      chk("areset_out_data",  aOutData,       32'h0);
      chk("areset_in_ready",  32'(aInReady),  32'd1);
      chk("areset_stall",     32'(aStall),    32'd0);
      chk("areset_c_stall",   32'(cStall),    32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      step();
      chk("post_reset_count", 32'(aCount), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
